// File: rtl/isa_pkg.sv
// Shared instruction-set definitions: format codes, 16-bit field positions
// and loader FSM states, common to the encoder and the decoder side.
package isa_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int RS_HI   = 11;
  localparam int RS_LO   = 9;
  localparam int RT_HI   = 8;
  localparam int RT_LO   = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 3;
  localparam int FUNK_HI = 2;
  localparam int FUNK_LO = 0;
  localparam int IIMM_HI = 5;
  localparam int IIMM_LO = 0;
  localparam int JIMM_HI = 11;
  localparam int JIMM_LO = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded instruction fields to a 16-bit word.
// Fields a format does not use are ignored; format 3 is flagged as illegal.
module instr_pack
  import isa_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [3:0]  op,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,
  input  logic [2:0]  funk,
  input  logic [11:0] imm,
  output logic [15:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (fmt)
      FMT_R: begin
        word[OP_HI:OP_LO]     = op;
        word[RS_HI:RS_LO]     = rs;
        word[RT_HI:RT_LO]     = rt;
        word[RD_HI:RD_LO]     = rd;
        word[FUNK_HI:FUNK_LO] = funk;
      end
      FMT_I: begin
        word[OP_HI:OP_LO]     = op;
        word[RS_HI:RS_LO]     = rs;
        word[RT_HI:RT_LO]     = rt;
        word[IIMM_HI:IIMM_LO] = imm[IIMM_HI:IIMM_LO];
      end
      FMT_J: begin
        word[OP_HI:OP_LO]     = op;
        word[JIMM_HI:JIMM_LO] = imm[JIMM_HI:JIMM_LO];
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Packs handshaked field sets into instruction words and writes them to
// consecutive instruction-memory addresses from a programmed base and count.
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [3:0]        op,
  input  logic [2:0]        rs,
  input  logic [2:0]        rt,
  input  logic [2:0]        rd,
  input  logic [2:0]        funk,
  input  logic [11:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state, state_next;
  logic [ADDR_W-1:0] addr_ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   accepted;
  logic [ADDR_W:0]   acked;
  logic [15:0]       word;
  logic              legal;
  logic              start_fire;
  logic              accept;
  logic              ack_fire;
  logic              last_ack;

  instr_pack u_pack (
    .fmt   (fmt),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .funk  (funk),
    .imm   (imm),
    .word  (word),
    .legal (legal)
  );

  assign accept   = in_valid && in_ready;
  assign ack_fire = mem_we && mem_ack;
  assign last_ack = ack_fire && ((acked + ONE) == remaining);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    start_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        start_fire = start;
        if (start && (count != '0)) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        in_ready = (accepted < remaining) && (!mem_we || mem_ack);
        if (last_ack) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // addr_ptr tracks the word in the output register; a word accepted while
  // that one is being acked targets the following address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_ptr  <= '0;
      remaining <= '0;
      accepted  <= '0;
      acked     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_fire) begin
        addr_ptr  <= base_addr;
        remaining <= count;
        accepted  <= '0;
        acked     <= '0;
        err       <= 1'b0;
        if (count == '0) done <= 1'b1;
      end
      if (ack_fire) begin
        mem_we   <= 1'b0;
        addr_ptr <= addr_ptr + 1'b1;
        acked    <= acked + ONE;
        if (last_ack) done <= 1'b1;
      end
      if (accept) begin
        if (legal) begin
          mem_we    <= 1'b1;
          mem_addr  <= mem_we ? addr_ptr + 1'b1 : addr_ptr;
          mem_wdata <= word;
          accepted  <= accepted + ONE;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
